// File: rtl/vga_apb_stream_ctrl.sv
// APB3-fed pixel FIFO driving a parametrised VGA raster; one pixel per clock.
// CPU pushes 24-bit RGB words, the raster pops one per active clock.
module vga_apb_stream_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [2:0]  in_pprot,
  input  logic [3:0]  in_pstrb,
  input  logic [31:0] in_pwdata,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_valid
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT + 1);
  localparam int VW = $clog2(VT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);

  logic          en_q, uf_q, valid_q, hs_q, vs_q;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   frame_q, frame_d;
  logic [23:0]   rgb_q;
  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [LW-1:0] lvl_q, lvl_d;

  logic       access, empty, full, active, pop, underflow_ev, stall;
  logic       wr_fire, push, ctrl_wr, errclr, flush;
  logic [2:0] sel;
  logic       unused_ok;

  assign unused_ok = ^{in_pprot, in_pstrb, in_paddr[31:5], in_paddr[1:0]};

  assign access       = in_psel & in_penable;
  assign sel          = in_paddr[4:2];
  assign empty        = (lvl_q == '0);
  assign full         = (lvl_q == LW'(FIFO_DEPTH));
  assign active       = en_q & (h_q < H_ACT) & (v_q < V_ACT);
  assign pop          = active & ~empty;
  assign underflow_ev = active & empty;
  // A PIXEL write into a full FIFO may only retire in a cycle that also pops.
  assign stall        = access & in_pwrite & (sel == 3'd2) & full & ~pop;
  assign in_pready    = access & ~stall;
  assign in_pslverr   = access & (sel > 3'd4);
  assign wr_fire      = in_pready & in_pwrite;
  assign push         = wr_fire & (sel == 3'd2);
  assign ctrl_wr      = wr_fire & (sel == 3'd0);
  assign errclr       = wr_fire & (sel == 3'd4);
  assign flush        = ctrl_wr & en_q & ~in_pwdata[0];

  always_comb begin
    in_prdata = '0;
    if (access & ~in_pwrite) begin
      case (sel)
        3'd0: in_prdata[0] = en_q;
        3'd1: begin
          in_prdata[0]       = empty;
          in_prdata[1]       = full;
          in_prdata[2]       = uf_q;
          in_prdata[16 +: LW] = lvl_q;
        end
        3'd3:    in_prdata = frame_q;
        default: in_prdata = '0;
      endcase
    end
  end

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    if (en_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d     = '0;
          frame_d = frame_q + 32'd1;
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end
    if (flush) begin
      h_d = '0;
      v_d = '0;
    end
  end

  always_comb begin
    lvl_d = lvl_q;
    if (flush) lvl_d = '0;
    else if (push & ~pop) lvl_d = lvl_q + LW'(1);
    else if (pop & ~push) lvl_d = lvl_q - LW'(1);
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= in_pwdata[23:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q    <= 1'b0;
      uf_q    <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      lvl_q   <= '0;
      rgb_q   <= '0;
      valid_q <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      lvl_q   <= lvl_d;
      if (ctrl_wr) en_q <= in_pwdata[0];
      // A new underflow outranks a clear landing in the same cycle.
      if (underflow_ev) uf_q <= 1'b1;
      else if (errclr)  uf_q <= 1'b0;
      if (flush) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        if (pop)  rd_q <= rd_q + AW'(1);
      end
      rgb_q   <= pop ? mem_q[rd_q] : 24'd0;
      valid_q <= active;
      hs_q    <= (h_q >= H_SS && h_q < H_SE) ? HS_POL : ~HS_POL;
      vs_q    <= (v_q >= V_SS && v_q < V_SE) ? VS_POL : ~VS_POL;
    end
  end

  assign vga_r     = rgb_q[23:16];
  assign vga_g     = rgb_q[15:8];
  assign vga_b     = rgb_q[7:0];
  assign vga_valid = valid_q;
  assign vga_hsync = hs_q;
  assign vga_vsync = vs_q;
endmodule

// File: tb/tb_vga_apb_stream_ctrl.sv
// Bench for vga_apb_stream_ctrl: raster-position/queue model checked every cycle,
// plus directed APB sequences with literal expectations.
module tb_vga_apb_stream_ctrl;
  localparam int HA = 4, HT = 8, VA = 2, VT = 5, FT = HT * VT, DEPTH = 4;

  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0]  pprot = '0;
  logic [3:0]  pstrb = 4'hF;
  logic        pready, pslverr, vga_hsync, vga_vsync, vga_valid;
  logic [31:0] prdata;
  logic [7:0]  vga_r, vga_g, vga_b;

  vga_apb_stream_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .in_paddr(paddr), .in_psel(psel), .in_penable(penable), .in_pwrite(pwrite),
    .in_pprot(pprot), .in_pstrb(pstrb), .in_pwdata(pwdata),
    .in_pready(pready), .in_prdata(prdata), .in_pslverr(pslverr),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_valid(vga_valid)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  bit chk_on = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raster position as a single pixel index within the frame, FIFO as a queue.
  bit          m_en = 0, m_uf = 0;
  int          m_pos = 0;
  logic [23:0] m_q[$];
  logic [31:0] m_frame = 0;
  logic [23:0] exp_rgb = 0;
  bit          exp_valid = 0, exp_hs = 0, exp_vs = 0;

  function automatic bit m_active();
    return m_en && (m_pos % HT) < HA && (m_pos / HT) < VA;
  endfunction

  function automatic bit m_ready();
    bit pop = m_active() && m_q.size() > 0;
    if (!(psel && penable)) return 0;
    return !(pwrite && paddr[4:2] == 3'd2 && m_q.size() == DEPTH && !pop);
  endfunction

  function automatic logic [31:0] m_rdata();
    if (!(psel && penable) || pwrite) return 0;
    case (paddr[4:2])
      3'd0: return {31'd0, m_en};
      3'd1: return (32'(m_q.size()) << 16) | {29'd0, m_uf, m_q.size() == DEPTH, m_q.size() == 0};
      3'd3: return m_frame;
      default: return 0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_en = 0; m_uf = 0; m_pos = 0; m_q.delete(); m_frame = 0;
      exp_rgb = 0; exp_valid = 0; exp_hs = 0; exp_vs = 0;
    end else begin
      int h, v;
      bit act, pop, und, wr;
      logic [2:0] a;
      h = m_pos % HT; v = m_pos / HT;
      act = m_active();
      pop = act && m_q.size() > 0;
      und = act && m_q.size() == 0;
      wr  = m_ready() && pwrite;
      a   = paddr[4:2];
      exp_valid = act;
      exp_rgb   = pop ? m_q[0] : 24'd0;
      exp_hs    = (h == 5 || h == 6);
      exp_vs    = (v == 3);
      if (m_en) begin
        if (m_pos == FT - 1) m_frame = m_frame + 1;
        m_pos = (m_pos + 1) % FT;
      end
      if (pop) void'(m_q.pop_front());
      if (wr && a == 3'd2) m_q.push_back(pwdata[23:0]);
      if (wr && a == 3'd4) m_uf = 0;
      if (und) m_uf = 1;
      if (wr && a == 3'd0) begin
        if (m_en && !pwdata[0]) begin
          m_q.delete();
          m_pos = 0;
        end
        m_en = pwdata[0];
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      check32("vga_rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, exp_rgb});
      check32("vga_valid_hs_vs", {29'd0, vga_valid, vga_hsync, vga_vsync},
              {29'd0, exp_valid, exp_hs, exp_vs});
      check32("pready", {31'd0, pready}, {31'd0, m_ready()});
      check32("prdata", prdata, m_rdata());
      check32("pslverr", {31'd0, pslverr},
              {31'd0, psel && penable && paddr[4:2] > 3'd4});
    end
  end

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input int maxc, output logic [31:0] rd, output bit ok,
                      output bit err, output int waits);
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clock); #1 penable = 1;
    ok = 0; err = 0; rd = 0; waits = 0;
    for (int n = 0; n < maxc && !ok; n++) begin
      @(negedge clock);
      if (pready) begin ok = 1; rd = prdata; err = pslverr; end
      else waits++;
    end
    @(posedge clock); #1 psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; bit ok, e; int w;
    xfer(1, a, d, 100, r, ok, e, w);
    check32("write_done", {31'd0, ok}, 32'd1);
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] r; bit ok, e; int w;
    xfer(0, a, 0, 100, r, ok, e, w);
    check32("read_done", {31'd0, ok}, 32'd1);
    check32(name, r, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset();
    reset = 1; idle(2); reset = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] r; bit ok, e; int w, n, hs_n, vs_n, va_n;
    @(posedge clock); #1 chk_on = 1;
    idle(1); reset = 0;

    // reset values
    rd_chk(32'h04, 32'h0000_0001, "status_reset");
    rd_chk(32'h0C, 32'h0, "frame_reset");
    rd_chk(32'h00, 32'h0, "ctrl_reset");

    // prefill with EN=0, then run: two pixels, then underflow
    wr(32'h08, 32'h0011_2233);
    wr(32'h08, 32'h0044_5566);
    rd_chk(32'h04, 32'h0002_0000, "status_level2");
    wr(32'h00, 32'h1);
    n = 0;
    while (!vga_valid && n < 50) begin @(negedge clock); n++; end
    check32("first_valid_seen", {31'd0, vga_valid}, 32'd1);
    check32("pixel0", {8'd0, vga_r, vga_g, vga_b}, 32'h0011_2233);
    @(negedge clock);
    check32("pixel1", {8'd0, vga_r, vga_g, vga_b}, 32'h0044_5566);
    @(negedge clock);
    check32("pixel2_underflow", {7'd0, vga_valid, vga_r, vga_g, vga_b}, 32'h0100_0000);
    @(negedge clock);
    check32("pixel3_underflow", {7'd0, vga_valid, vga_r, vga_g, vga_b}, 32'h0100_0000);
    @(posedge clock); #1;
    rd_chk(32'h04, 32'h0000_0005, "status_underflow");

    // disable flushes, ERRCLR clears
    wr(32'h00, 32'h0);
    wr(32'h10, 32'h0);
    rd_chk(32'h04, 32'h0000_0001, "status_errclr");

    // frame counter edge and sync/valid pulse counts over one frame
    do_reset();
    wr(32'h00, 32'h1);
    idle(36);
    rd_chk(32'h0C, 32'd0, "frame_before_40");
    idle(2);
    rd_chk(32'h0C, 32'd1, "frame_after_40");
    hs_n = 0; vs_n = 0; va_n = 0;
    repeat (FT) begin
      @(negedge clock);
      hs_n += int'(vga_hsync); vs_n += int'(vga_vsync); va_n += int'(vga_valid);
    end
    check32("hsync_per_frame", hs_n, 32'd10);
    check32("vsync_per_frame", vs_n, 32'd8);
    check32("valid_per_frame", va_n, 32'd8);
    @(posedge clock); #1;
    wr(32'h00, 32'h0);

    // back-pressure: stall with EN=0 persists
    do_reset();
    for (int i = 0; i < DEPTH; i++) wr(32'h08, 32'h00A0_0000 + i);
    xfer(1, 32'h08, 32'h00DE_AD01, 8, r, ok, e, w);
    check32("stall_en0_not_done", {31'd0, ok}, 32'd0);
    rd_chk(32'h04, 32'h0004_0002, "status_full");

    // with EN=1: refill during blanking, fifth push waits for next frame's first pop
    wr(32'h00, 32'h1);
    idle(12);
    for (int i = 0; i < DEPTH; i++) wr(32'h08, 32'h00B0_0000 + i);
    xfer(1, 32'h08, 32'h00C0_FFEE, 100, r, ok, e, w);
    check32("stalled_push_done", {31'd0, ok}, 32'd1);
    check32("stalled_push_waits", w, 32'd19);

    // ERRCLR coinciding with the last active underflow: set wins
    wr(32'h00, 32'h0);
    wr(32'h10, 32'h0);
    rd_chk(32'h04, 32'h0000_0001, "status_cleared");
    wr(32'h00, 32'h1);
    idle(10);
    wr(32'h10, 32'h0);
    rd_chk(32'h04, 32'h0000_0005, "status_set_wins");

    // unmapped offset, RO write, WO read
    xfer(0, 32'h14, 0, 10, r, ok, e, w);
    check32("bad_read_err", {30'd0, ok, e}, 32'd3);
    check32("bad_read_data", r, 32'd0);
    xfer(1, 32'h1C, 32'h1, 10, r, ok, e, w);
    check32("bad_write_err", {30'd0, ok, e}, 32'd3);
    xfer(1, 32'h04, 32'hFFFF_FFFF, 10, r, ok, e, w);
    check32("ro_write_noerr", {30'd0, ok, e}, 32'd2);
    xfer(0, 32'h08, 0, 10, r, ok, e, w);
    check32("wo_read_zero", {30'd0, ok, e}, 32'd2);
    check32("wo_read_data", r, 32'd0);

    // reset in the middle of an active line
    wr(32'h00, 32'h0);
    wr(32'h08, 32'h00AA_BBCC);
    wr(32'h08, 32'h00DD_EEFF);
    wr(32'h00, 32'h1);
    idle(1);
    @(negedge clock);
    check32("pre_reset_pixel", {7'd0, vga_valid, vga_r, vga_g, vga_b}, 32'h01AA_BBCC);
    reset = 1;
    @(posedge clock); @(negedge clock);
    check32("reset_outputs", {5'd0, vga_valid, vga_hsync, vga_vsync, vga_r, vga_g, vga_b},
            32'h0);
    reset = 0;
    @(posedge clock); #1;
    rd_chk(32'h04, 32'h0000_0001, "status_after_reset");
    rd_chk(32'h00, 32'h0, "ctrl_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
